baser_257b_transcoder: RTL and testbench



---
 rtl/baser_257b_transcoder_if.sv | 33 +++
 rtl/baser_257b_transcoder.sv | 134 +++++++++++++
 tb/tb_baser_257b_transcoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/baser_257b_transcoder_if.sv
// rtl/baser_257b_transcoder_if.sv - 66b block input and 257b transcoded output stream bundle
interface baser_257b_transcoder_if #(
    parameter int BLK_WIDTH = 66,
    parameter int TC_WIDTH  = 257
);
    logic                 i_valid;
    logic [BLK_WIDTH-1:0] i_block;
    logic                 o_ready;
    logic [TC_WIDTH-1:0]  o_tx_coded;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_hdr_err;

    modport slave (
        input  i_valid,
        input  i_block,
        output o_ready,
        output o_tx_coded,
        output o_valid,
        input  i_ready,
        output o_hdr_err
    );

    modport master (
        output i_valid,
        output i_block,
        input  o_ready,
        input  o_tx_coded,
        input  o_valid,
        output i_ready,
        input  o_hdr_err
    );
endinterface

// File: rtl/baser_257b_transcoder.sv
// rtl/baser_257b_transcoder.sv - packs four 64b/66b blocks into one 257b transcoded block
module baser_257b_transcoder #(
    parameter int DATA_WIDTH = 64,
    parameter int SH_WIDTH   = 2,
    parameter int BLK_WIDTH  = DATA_WIDTH + 2,
    parameter int TC_WIDTH   = 4 * DATA_WIDTH + 1,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    baser_257b_transcoder_if.slave     bus,
    output logic [31:0]                o_xcode_count,
    output logic [31:0]                o_ctrl_count,
    output logic [31:0]                o_hdr_err_count
);

    logic [1:0]            slot_k;
    logic [DATA_WIDTH-1:0] slot_pay [NUM_BLOCKS-1];
    logic [NUM_BLOCKS-2:0] slot_h;
    logic [NUM_BLOCKS-2:0] slot_err;

    logic [SH_WIDTH-1:0]   in_sync;
    logic                  in_h;
    logic                  in_err;
    logic                  accept;
    logic                  load;
    logic                  drain;

    logic [DATA_WIDTH-1:0] pay [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] hv;
    logic [NUM_BLOCKS-1:0] ev;
    int                    first_ctrl;
    logic [TC_WIDTH-1:0]   tc;

    assign in_sync = bus.i_block[SH_WIDTH-1:0];
    assign in_h    = (in_sync == 2'b01);
    assign in_err  = (in_sync[0] == in_sync[1]);

    // Slot 3 never waits in the accumulator: the group is transcoded straight off the input.
    assign bus.o_ready = (slot_k != 2'd3) || !bus.o_valid || bus.i_ready;
    assign accept      = bus.i_valid && bus.o_ready;
    assign load        = accept && (slot_k == 2'd3);
    assign drain       = bus.o_valid && bus.i_ready;

    always_comb begin
        for (int k = 0; k < NUM_BLOCKS - 1; k++) begin
            pay[k] = slot_pay[k];
        end
        pay[NUM_BLOCKS-1] = bus.i_block[BLK_WIDTH-1:SH_WIDTH];
        hv = {in_h, slot_h};
        ev = {in_err, slot_err};
    end

    always_comb begin
        first_ctrl = NUM_BLOCKS;
        for (int k = NUM_BLOCKS - 1; k >= 0; k--) begin
            if (!hv[k]) begin
                first_ctrl = k;
            end
        end
    end

    // The first control block gives up its low type nibble to make room for the 4b header map.
    always_comb begin
        tc = '0;
        if (&hv) begin
            tc = {pay[3], pay[2], pay[1], pay[0], 1'b1};
        end else begin
            tc[4:1] = hv;
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                if (k < first_ctrl) begin
                    tc[5 + DATA_WIDTH*k +: DATA_WIDTH] = pay[k];
                end else if (k == first_ctrl) begin
                    tc[5 + DATA_WIDTH*k +: DATA_WIDTH-4] = {pay[k][DATA_WIDTH-1:8], pay[k][7:4]};
                end else begin
                    tc[1 + DATA_WIDTH*k +: DATA_WIDTH] = pay[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_k   <= 2'd0;
            slot_h   <= '0;
            slot_err <= '0;
            for (int s = 0; s < NUM_BLOCKS - 1; s++) begin
                slot_pay[s] <= '0;
            end
        end else if (accept) begin
            slot_k <= slot_k + 2'd1;
            for (int s = 0; s < NUM_BLOCKS - 1; s++) begin
                if (slot_k == 2'(s)) begin
                    slot_pay[s] <= bus.i_block[BLK_WIDTH-1:SH_WIDTH];
                    slot_h[s]   <= in_h;
                    slot_err[s] <= in_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_valid    <= 1'b0;
            bus.o_tx_coded <= '0;
            bus.o_hdr_err  <= 1'b0;
        end else if (load) begin
            bus.o_valid    <= 1'b1;
            bus.o_tx_coded <= tc;
            bus.o_hdr_err  <= |ev;
        end else if (drain) begin
            bus.o_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_xcode_count   <= '0;
            o_ctrl_count    <= '0;
            o_hdr_err_count <= '0;
        end else begin
            if (drain) begin
                o_xcode_count <= o_xcode_count + 32'd1;
                if (!bus.o_tx_coded[0]) begin
                    o_ctrl_count <= o_ctrl_count + 32'd1;
                end
            end
            if (accept && in_err) begin
                o_hdr_err_count <= o_hdr_err_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// tb/tb_baser_257b_transcoder.sv - directed self-checking bench for baser_257b_transcoder
module tb_baser_257b_transcoder;

    localparam logic [63:0] PAA = 64'hAAAA_AAAA_AAAA_AAAA;

    logic        clk;
    logic        rst_n;
    logic [31:0] xcode_count;
    logic [31:0] ctrl_count;
    logic [31:0] hdr_err_count;
    int          n_cmp;
    int          n_err;
    logic [256:0] exp_a;
    logic [256:0] exp_b;

    baser_257b_transcoder_if bus ();

    baser_257b_transcoder dut (
        .clk             (clk),
        .i_rst_n         (rst_n),
        .bus             (bus.slave),
        .o_xcode_count   (xcode_count),
        .o_ctrl_count    (ctrl_count),
        .o_hdr_err_count (hdr_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [1:0] sync, input logic [63:0] payload);
        int cnt;
        bus.i_valid = 1'b1;
        bus.i_block = {payload, sync};
        cnt = 0;
        #1;
        while (!bus.o_ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 100) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout observed=%0d expected=<100", cnt);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_block = '0;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 257'(bus.o_valid), 257'd0);
        check("rst_tx", bus.o_tx_coded, 257'd0);
        check("rst_xcode", 257'(xcode_count), 257'd0);
        check("rst_hdrcnt", 257'(hdr_err_count), 257'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 257'(bus.o_ready), 257'd1);

        // all-data group
        send(2'b01, PAA);
        send(2'b01, PAA);
        send(2'b01, PAA);
        check("t1_no_early_valid", 257'(bus.o_valid), 257'd0);
        send(2'b01, PAA);
        check("t1_valid", 257'(bus.o_valid), 257'd1);
        check("t1_tx", bus.o_tx_coded, {PAA, PAA, PAA, PAA, 1'b1});
        check("t1_hdr_err", 257'(bus.o_hdr_err), 257'd0);
        @(posedge clk);
        #1;
        check("t1_drained", 257'(bus.o_valid), 257'd0);
        check("t1_xcode", 257'(xcode_count), 257'd1);
        check("t1_ctrl", 257'(ctrl_count), 257'd0);

        // first block control type 1E
        send(2'b10, 64'h5555_5555_5555_551E);
        send(2'b01, PAA);
        send(2'b01, PAA);
        send(2'b01, PAA);
        exp_a = '0;
        exp_a[4:1]    = 4'b1110;
        exp_a[8:5]    = 4'h1;
        exp_a[64:9]   = 56'h55_5555_5555_5555;
        exp_a[256:65] = {PAA, PAA, PAA};
        check("t2_tx", bus.o_tx_coded, exp_a);
        @(posedge clk);
        #1;
        check("t2_ctrl", 257'(ctrl_count), 257'd1);
        check("t2_xcode", 257'(xcode_count), 257'd2);

        // two data then two control blocks
        send(2'b01, PAA);
        send(2'b01, PAA);
        send(2'b10, 64'h1122_3344_5566_77FF);
        send(2'b10, 64'h8899_AABB_CCDD_EE87);
        exp_a = '0;
        exp_a[4:1]     = 4'b0011;
        exp_a[68:5]    = PAA;
        exp_a[132:69]  = PAA;
        exp_a[192:133] = {56'h11_2233_4455_6677, 4'hF};
        exp_a[256:193] = 64'h8899_AABB_CCDD_EE87;
        check("t3_tx", bus.o_tx_coded, exp_a);
        check("t3_type3", 257'(bus.o_tx_coded[200:193]), 257'h87);
        @(posedge clk);
        #1;
        check("t3_ctrl", 257'(ctrl_count), 257'd2);

        // invalid sync header on block 1
        send(2'b01, PAA);
        send(2'b11, 64'h0123_4567_89AB_CDEF);
        send(2'b01, PAA);
        send(2'b01, PAA);
        exp_a = '0;
        exp_a[4:1]     = 4'b1101;
        exp_a[68:5]    = PAA;
        exp_a[128:69]  = {56'h01_2345_6789_ABCD, 4'hE};
        exp_a[192:129] = PAA;
        exp_a[256:193] = PAA;
        check("t5_tx", bus.o_tx_coded, exp_a);
        check("t5_hdr_err", 257'(bus.o_hdr_err), 257'd1);
        check("t5_hdr_cnt", 257'(hdr_err_count), 257'd1);
        @(posedge clk);
        #1;
        check("t5_ctrl", 257'(ctrl_count), 257'd3);
        check("t5_xcode", 257'(xcode_count), 257'd4);

        // backpressure: 8 blocks with downstream stalled
        bus.i_ready = 1'b0;
        send(2'b01, 64'h1111_1111_1111_1111);
        send(2'b01, 64'h2222_2222_2222_2222);
        send(2'b01, 64'h3333_3333_3333_3333);
        send(2'b01, 64'h4444_4444_4444_4444);
        send(2'b01, 64'h5555_5555_5555_5555);
        send(2'b01, 64'h6666_6666_6666_6666);
        send(2'b01, 64'h7777_7777_7777_7777);
        exp_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 1'b1};
        exp_b = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555, 1'b1};
        bus.i_valid = 1'b1;
        bus.i_block = {64'h8888_8888_8888_8888, 2'b01};
        #1;
        check("t4_stall_ready", 257'(bus.o_ready), 257'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_hold_valid", 257'(bus.o_valid), 257'd1);
        check("t4_hold_tx", bus.o_tx_coded, exp_a);
        check("t4_hold_xcode", 257'(xcode_count), 257'd4);
        bus.i_ready = 1'b1;
        #1;
        check("t4_release_ready", 257'(bus.o_ready), 257'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        check("t4_b_valid", 257'(bus.o_valid), 257'd1);
        check("t4_b_tx", bus.o_tx_coded, exp_b);
        check("t4_a_count", 257'(xcode_count), 257'd5);
        @(posedge clk);
        #1;
        check("t4_b_drained", 257'(bus.o_valid), 257'd0);
        check("t4_b_count", 257'(xcode_count), 257'd6);

        // reset mid-group
        send(2'b01, PAA);
        send(2'b10, 64'h0000_0000_0000_001E);
        rst_n = 1'b0;
        #1;
        check("t6_rst_xcode", 257'(xcode_count), 257'd0);
        check("t6_rst_ctrl", 257'(ctrl_count), 257'd0);
        check("t6_rst_hdrcnt", 257'(hdr_err_count), 257'd0);
        check("t6_rst_tx", bus.o_tx_coded, 257'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2'b01, 64'hDEAD_BEEF_0000_0000);
        send(2'b01, 64'hDEAD_BEEF_0000_0001);
        send(2'b01, 64'hDEAD_BEEF_0000_0002);
        check("t6_no_early_valid", 257'(bus.o_valid), 257'd0);
        send(2'b01, 64'hDEAD_BEEF_0000_0003);
        check("t6_tx", bus.o_tx_coded,
              {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
               64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000, 1'b1});
        @(posedge clk);
        #1;
        check("t6_xcode", 257'(xcode_count), 257'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
